// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths, typedefs and constants.
//   XLEN     - data width of a register write
//   RA_W     - register address width
//   reg_addr_t / word_t - register address and data word types
//   REG_ZERO - address of the hard-wired zero register
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int RA_W = 5;
    typedef logic [RA_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0] word_t;
    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first set request at or after ptr.
//   req_in   - request vector
//   ptr_in   - highest-priority index this cycle
//   gnt_out  - one-hot grant (all zero when nothing requested)
//   idx_out  - encoded index of the granted request
//   any_out  - high when some request was granted
module rr_priority_picker
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_in,
    output logic [NUM_REQ-1:0]         gnt_out,
    output logic [$clog2(NUM_REQ)-1:0] idx_out,
    output logic                       any_out
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] w_j;
    // Walk offsets from farthest to nearest so the closest requester to ptr wins.
    always_comb begin
        idx_out = '0;
        any_out = 1'b0;
        w_j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = IW'((int'(ptr_in) + k) % NUM_REQ);
            if (req_in[w_j]) begin
                idx_out = w_j;
                any_out = 1'b1;
            end
        end
        gnt_out = any_out ? NUM_REQ'(1) << idx_out : '0;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin sharing of the register-file write port among NUM_REQ producers.
//   clk_in, rst_in     - clock, synchronous active-high reset
//   req_valid_in       - per-requester write request
//   req_wa_in/wd_in    - packed per-requester address / data
//   req_ready_out      - one-hot acceptance, combinational from valid
//   hold_in            - freezes writeback (no grant, pointer held)
//   we_out/wa_out/wd_out/grant_id_out - registered write port, one cycle after the grant
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int RA_W    = cpu_pkg::RA_W
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [NUM_REQ*RA_W-1:0]    req_wa_in,
    input  logic [NUM_REQ*XLEN-1:0]    req_wd_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    input  logic                       hold_in,
    output logic                       we_out,
    output logic [RA_W-1:0]            wa_out,
    output logic [XLEN-1:0]            wd_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_out
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic [RA_W-1:0]    w_wa;
    logic [XLEN-1:0]    w_wd;
    // Masking the requests (not the grant) keeps ready a pure function of valid.
    assign w_req = (rst_in || hold_in) ? '0 : req_valid_in;
    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_in  (w_req),
        .ptr_in  (r_ptr),
        .gnt_out (w_gnt),
        .idx_out (w_idx),
        .any_out (w_any)
    );
    assign req_ready_out = w_gnt;
    assign w_wa = req_wa_in[w_idx*RA_W +: RA_W];
    assign w_wd = req_wd_in[w_idx*XLEN +: XLEN];
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ptr        <= '0;
            we_out       <= 1'b0;
            wa_out       <= '0;
            wd_out       <= '0;
            grant_id_out <= '0;
        end else begin
            // x0 writes are accepted and shown on the port but never enabled.
            we_out <= w_any && (w_wa != RA_W'(REG_ZERO));
            if (w_any) begin
                wa_out       <= w_wa;
                wd_out       <= w_wd;
                grant_id_out <= w_idx;
                r_ptr        <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: scoreboard bench for writeback_arbiter (NUM_REQ=4).
module tb_writeback_arbiter;
    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  id;
    } wb_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [3:0]  valid = 4'b0;
    logic [4:0]  pwa [4];
    logic [31:0] pwd [4];
    logic [19:0] req_wa;
    logic [127:0] req_wd;
    logic [3:0]  ready;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  gid;
    wb_t         sbq [$];
    wb_t         m_last = '0;
    logic [1:0]  m_ptr = 2'd0;
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_wa[i*5 +: 5]   = pwa[i];
            req_wd[i*32 +: 32] = pwd[i];
        end
    end
    writeback_arbiter #(.NUM_REQ(4), .XLEN(32), .RA_W(5)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req_valid_in  (valid),
        .req_wa_in     (req_wa),
        .req_wd_in     (req_wd),
        .req_ready_out (ready),
        .hold_in       (hold),
        .we_out        (we),
        .wa_out        (wa),
        .wd_out        (wd),
        .grant_id_out  (gid)
    );
    // One clock: check ready against the model, push the expected port value, then pop and compare.
    task automatic step();
        logic [3:0] eg;
        logic [1:0] j;
        logic [1:0] g;
        logic       found;
        wb_t        e;
        wb_t        got;
        #1;
        eg = 4'b0;
        g = 2'd0;
        found = 1'b0;
        if (!rst && !hold) begin
            for (int k = 0; k < 4; k++) begin
                j = m_ptr + 2'(k);
                if (!found && valid[j]) begin
                    g = j;
                    found = 1'b1;
                end
            end
        end
        if (found) eg[g] = 1'b1;
        checks++;
        if (ready !== eg) begin
            errors++;
            $display("FAIL ready: got %b expected %b", ready, eg);
        end
        @(posedge clk);
        if (rst) begin
            e = '0;
            m_ptr = 2'd0;
        end else if (found) begin
            e.we = (pwa[g] != 5'd0);
            e.wa = pwa[g];
            e.wd = pwd[g];
            e.id = g;
            m_ptr = g + 2'd1;
        end else begin
            e = m_last;
            e.we = 1'b0;
        end
        m_last = e;
        sbq.push_back(e);
        #1;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            e = sbq.pop_front();
            got = '{we: we, wa: wa, wd: wd, id: gid};
            if (got !== e) begin
                errors++;
                $display("FAIL port: got we=%b wa=%0d wd=%h id=%0d expected we=%b wa=%0d wd=%h id=%0d",
                         got.we, got.wa, got.wd, got.id, e.we, e.wa, e.wd, e.id);
            end
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            pwa[i] = 5'(i + 1);
            pwd[i] = 32'h100 + i;
        end
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({we, wa, wd, gid} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h id=%0d expected all zero", we, wa, wd, gid);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gid !== 2'd0 || we !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got id=%0d we=%b expected id=0 we=1", gid, we);
        end
    endtask
    task automatic test_single();
        valid = 4'b0100;
        pwa[2] = 5'd7;
        pwd[2] = 32'hDEADBEEF;
        step();
        checks++;
        if (we !== 1'b1 || wa !== 5'd7 || wd !== 32'hDEADBEEF || gid !== 2'd2) begin
            errors++;
            $display("FAIL single: got we=%b wa=%0d wd=%h id=%0d expected 1 7 deadbeef 2", we, wa, wd, gid);
        end
        valid = 4'b1111;
        step();
        checks++;
        if (gid !== 2'd3) begin
            errors++;
            $display("FAIL single_ptr: got id=%0d expected 3", gid);
        end
    endtask
    task automatic test_fairness();
        logic [4:0] exp_wa [8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1, 5'd2, 5'd3, 5'd4};
        do_reset();
        valid = 4'b1111;
        for (int i = 0; i < 4; i++) pwa[i] = 5'(i + 1);
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (we !== 1'b1 || wa !== exp_wa[c]) begin
                errors++;
                $display("FAIL fairness[%0d]: got we=%b wa=%0d expected we=1 wa=%0d", c, we, wa, exp_wa[c]);
            end
        end
    endtask
    task automatic test_wrap_skip();
        logic [1:0] exp_id [3] = '{2'd0, 2'd2, 2'd0};
        valid = 4'b0100;
        step();
        valid = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (gid !== exp_id[c]) begin
                errors++;
                $display("FAIL wrap_skip[%0d]: got id=%0d expected %0d", c, gid, exp_id[c]);
            end
        end
    endtask
    task automatic test_x0();
        valid = 4'b0001;
        pwa[0] = 5'd0;
        pwd[0] = 32'd5;
        step();
        checks++;
        if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd5 || gid !== 2'd0) begin
            errors++;
            $display("FAIL x0: got we=%b wa=%0d wd=%h id=%0d expected 0 0 5 0", we, wa, wd, gid);
        end
        pwa[0] = 5'd9;
    endtask
    task automatic test_hold();
        valid = 4'b0001;
        step();
        valid = 4'b0011;
        hold = 1'b1;
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (we !== 1'b0 || ready !== 4'b0000) begin
            errors++;
            $display("FAIL hold: got we=%b ready=%b expected we=0 ready=0000", we, ready);
        end
        hold = 1'b0;
        step();
        checks++;
        if (gid !== 2'd1 || we !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got id=%0d we=%b expected id=1 we=1", gid, we);
        end
    endtask
    task automatic test_reset_mid();
        valid = 4'b1111;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got we=%b expected 0", we);
        end
        rst = 1'b0;
    endtask
    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            valid = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) begin
                pwa[i] = 5'($urandom_range(0, 31));
                pwd[i] = $urandom;
            end
            step();
        end
        hold = 1'b0;
    endtask
    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap_skip();
        test_x0();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
